ram_bus_master: RTL and testbench
=================================

Name: ram_bus_master

Overview:
- Initiator-side controller for the team's single-port synchronous RAM bus (cs/we/oe/addr/indirect_addr, shared tristate data).
- Accepts simple read/write requests over a valid/ready handshake and sequences the RAM bus pins.
- Returns read data on a response strobe.
- Supports indirect access: a 12-bit pointer is fetched from two consecutive RAM bytes, then the target access is performed at that pointer.

Parameters:
ADDR_WIDTH, 12, RAM address width; pointer width for indirect mode.
DATA_WIDTH, 8, RAM data width; indirect mode requires ADDR_WIDTH <= 2*DATA_WIDTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_we  input  1  1 = write, 0 = read
req_indirect  input  1  1 = req_addr points at pointer bytes
req_addr  input  ADDR_WIDTH  direct address or pointer location
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion strobe (reads and writes)
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid; holds last value otherwise
mem_cs  output  1  RAM chip select
mem_we  output  1  RAM write enable
mem_oe  output  1  RAM output enable (1 = RAM drives mem_data)
mem_addr  output  ADDR_WIDTH  RAM address
mem_indirect_addr  output  ADDR_WIDTH  resolved pointer during target access of an indirect request, else 0
mem_data  inout  DATA_WIDTH  shared bus; driven by controller only in WR, else high-Z

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, mem_cs=0, mem_we=0, mem_oe=0, mem_addr=0, mem_indirect_addr=0, mem_data=Z.
- Handshake: request accepted on the clk edge with req_valid & req_ready. All request fields are latched at accept. req_ready=0 in every state but IDLE.
- RAM protocol:
  - Write: mem_cs=1, mem_we=1, mem_oe=0, controller drives mem_data; RAM writes on that edge.
  - Read issue: mem_cs=1, mem_we=0, mem_oe=1.
  - Read wait: mem_cs=1, mem_oe=1, same address. Data sampled from mem_data at the end of the wait cycle (1-cycle RAM latency).
- States: IDLE, PTR_LO, PTR_LO_W, PTR_HI, PTR_HI_W, TURN, WR, RD, RD_W, RESP.
- Transitions from IDLE on accept:
  - Direct write -> WR.
  - Direct read -> RD.
  - Indirect -> PTR_LO.
- Transitions after fetch and access:
  - PTR_LO (addr=req_addr) -> PTR_LO_W: capture pointer[7:0].
  - PTR_HI (addr=req_addr+1, wraps mod 2^ADDR_WIDTH) -> PTR_HI_W: capture pointer[ADDR_WIDTH-1:8] from the low bits of the byte; upper bits ignored.
  - PTR_HI_W -> TURN if write, RD if read. TURN is a bus-turnaround cycle with all mem_* deasserted.
  - WR -> RESP; RD -> RD_W -> RESP; RESP -> IDLE.
- During WR/RD/RD_W of an indirect request: mem_addr=pointer and mem_indirect_addr=pointer.
- Latency in cycles after the accept edge until rsp_valid:
  - Direct write: 2.
  - Direct read: 3.
  - Indirect write: 7.
  - Indirect read: 7.
- RESP: rsp_valid=1 for exactly one cycle; no backpressure. rsp_rdata is updated only for reads.
- mem_data is never driven by the controller while mem_oe=1.
- Reset mid-operation: next edge returns to IDLE with reset values. The in-flight request is dropped and no rsp_valid is generated.
- Unused outputs in IDLE/RESP/TURN: mem_cs=mem_we=mem_oe=0, mem_addr holds last value.

Optional Feature:
- Macro: RAM_BUS_MASTER_STATS_EN.
- When defined:
  - Adds outputs stat_rd_count[15:0] and stat_wr_count[15:0].
  - Each increments once per completed read/write (in RESP) and saturates at 0xFFFF.
  - Cleared by rst.
  - Pointer fetches are not counted.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Direct write 0x3A to 0x005, then direct read 0x005 -> write rsp_valid 2 cycles after accept; read rsp_valid 3 cycles after accept with rsp_rdata=0x3A.
- Preload mem[0x010]=0x34, mem[0x011]=0xF2; indirect write 0x5C at req_addr 0x010, then indirect read 0x010:
  - mem[0x234]=0x5C.
  - mem_indirect_addr=0x234 during access.
  - Read returns 0x5C at cycle 7.
- Pointer wrap: mem[0xFFF]=0x01, mem[0x000]=0x00; indirect read at 0xFFF -> PTR_HI issues mem_addr=0x000 and the target is 0x001.
- req_valid held high with 4 queued requests -> req_ready low from accept until the cycle after RESP. No request is lost or duplicated, and mem_data is never driven while mem_oe=1.
- Assert rst during PTR_HI_W of an indirect write -> next cycle IDLE, all mem_* 0, mem_data Z, no rsp_valid, target location unchanged.
- With RAM_BUS_MASTER_STATS_EN defined: 3 reads + 2 writes (one of them indirect) -> stat_rd_count=3, stat_wr_count=2.

Source files
------------

// File: rtl/ram_bus_master.sv
// Initiator for the single-port synchronous RAM bus: valid/ready requests, direct or pointer-indirect access.
// Define RAM_BUS_MASTER_STATS_EN to add saturating completed-read/write counters.
module ram_bus_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_indirect,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] mem_indirect_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
`ifdef RAM_BUS_MASTER_STATS_EN
  ,
  output logic [15:0]           stat_rd_count,
  output logic [15:0]           stat_wr_count
`endif
);

  // Pointer bits taken from the second pointer byte; its upper bits are ignored.
  localparam int HI_W = ADDR_WIDTH - DATA_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_PTR_LO, S_PTR_LO_W, S_PTR_HI, S_PTR_HI_W,
    S_TURN, S_WR, S_RD, S_RD_W, S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_ptr_lo;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_drive;

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_ptr      = {mem_data[HI_W-1:0], r_ptr_lo};
  assign w_addr_inc = r_addr + 1'b1;

  // NOTE: the bus is released whenever r_drive is low; r_drive is only set for the WR cycle, where mem_oe is 0.
  assign mem_data = r_drive ? r_wdata : 'z;

  // NOTE: every state and output register uses non-blocking assignment so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      req_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_rdata         <= '0;
      mem_cs            <= 1'b0;
      mem_we            <= 1'b0;
      mem_oe            <= 1'b0;
      mem_addr          <= '0;
      mem_indirect_addr <= '0;
      r_drive           <= 1'b0;
      r_we              <= 1'b0;
      r_addr            <= '0;
      r_wdata           <= '0;
      r_ptr_lo          <= '0;
      r_ptr             <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            mem_cs    <= 1'b1;
            mem_addr  <= req_addr;
            if (req_indirect) begin
              r_state <= S_PTR_LO;
              mem_oe  <= 1'b1;
            end else if (req_we) begin
              r_state <= S_WR;
              mem_we  <= 1'b1;
              r_drive <= 1'b1;
            end else begin
              r_state <= S_RD;
              mem_oe  <= 1'b1;
            end
          end
        end
        S_PTR_LO: r_state <= S_PTR_LO_W;
        S_PTR_LO_W: begin
          r_ptr_lo <= mem_data;
          mem_addr <= w_addr_inc;
          r_state  <= S_PTR_HI;
        end
        S_PTR_HI: r_state <= S_PTR_HI_W;
        S_PTR_HI_W: begin
          r_ptr <= w_ptr;
          if (r_we) begin
            // Turnaround: RAM releases the bus before the controller drives it.
            r_state <= S_TURN;
            mem_cs  <= 1'b0;
            mem_oe  <= 1'b0;
          end else begin
            r_state           <= S_RD;
            mem_addr          <= w_ptr;
            mem_indirect_addr <= w_ptr;
          end
        end
        S_TURN: begin
          r_state           <= S_WR;
          mem_cs            <= 1'b1;
          mem_we            <= 1'b1;
          mem_addr          <= r_ptr;
          mem_indirect_addr <= r_ptr;
          r_drive           <= 1'b1;
        end
        S_WR: begin
          r_state           <= S_RESP;
          mem_cs            <= 1'b0;
          mem_we            <= 1'b0;
          r_drive           <= 1'b0;
          mem_indirect_addr <= '0;
          rsp_valid         <= 1'b1;
        end
        S_RD: r_state <= S_RD_W;
        S_RD_W: begin
          r_state           <= S_RESP;
          rsp_rdata         <= mem_data;
          rsp_valid         <= 1'b1;
          mem_cs            <= 1'b0;
          mem_oe            <= 1'b0;
          mem_indirect_addr <= '0;
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RAM_BUS_MASTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_count <= '0;
      stat_wr_count <= '0;
    end else if (r_state == S_RESP) begin
      if (r_we) begin
        if (stat_wr_count != 16'hFFFF) stat_wr_count <= stat_wr_count + 16'd1;
      end else if (stat_rd_count != 16'hFFFF) begin
        stat_rd_count <= stat_rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural RAM on the shared bus plus an address-level reference memory.
// Build with RAM_BUS_MASTER_STATS_EN to include the counter checks.
module tb_ram_bus_master;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, req_indirect = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, mem_cs, mem_we, mem_oe;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr, mem_indirect_addr;
  wire  [DW-1:0] mem_data;
`ifdef RAM_BUS_MASTER_STATS_EN
  logic [15:0]   stat_rd_count, stat_wr_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_indirect_addr(mem_indirect_addr),
`ifdef RAM_BUS_MASTER_STATS_EN
    .stat_rd_count(stat_rd_count), .stat_wr_count(stat_wr_count),
`endif
    .mem_data(mem_data)
  );

  // Synchronous RAM, one-cycle read latency, drives the bus while mem_oe is high.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q = '0;
  logic          ram_init = 1'b0, pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i * 37 + 11);
      ram_q <= '0;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_cs === 1'b1) begin
      if (mem_we === 1'b1)      ram[mem_addr] <= mem_data;
      else if (mem_oe === 1'b1) ram_q <= ram[mem_addr];
    end
  end

  assign mem_data = mem_oe ? ram_q : 'z;

  // Reference model: plain memory image and the last returned read value.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_hold = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic rv, rr, cs, we, oe, input logic [AW-1:0] a, ind);
    return {3'b000, rv, rr, cs, we, oe, a, ind};
  endfunction

  function automatic logic [31:0] obs();
    return pk(rsp_valid, req_ready, mem_cs, mem_we, mem_oe, mem_addr, mem_indirect_addr);
  endfunction

  function automatic int latency(input bit we, input bit ind);
    return ind ? 7 : (we ? 2 : 3);
  endfunction

  function automatic logic [AW-1:0] target(input bit ind, input logic [AW-1:0] a);
    logic [AW-1:0] a1;
    a1 = a + 1'b1;
    return ind ? AW'({ref_mem[a1], ref_mem[a]}) : a;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One request from idle; checks the bus/handshake trace cycle by cycle and the response.
  task automatic do_req(input bit we, input bit ind, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [31:0]   tr [8];
    logic [AW-1:0] a1, tgt;
    logic [DW-1:0] exp_rd;
    int            n, lat;
    a1  = a + 1'b1;
    tgt = target(ind, a);
    lat = latency(we, ind);
    n   = 0;
    if (ind) begin
      tr[0] = pk(0, 0, 1, 0, 1, a, '0);
      tr[1] = tr[0];
      tr[2] = pk(0, 0, 1, 0, 1, a1, '0);
      tr[3] = tr[2];
      if (we) tr[4] = pk(0, 0, 0, 0, 0, a1, '0);
      else    tr[4] = pk(0, 0, 1, 0, 1, tgt, tgt);
      tr[5] = we ? pk(0, 0, 1, 1, 0, tgt, tgt) : tr[4];
      n = 6;
    end else if (we) begin
      tr[0] = pk(0, 0, 1, 1, 0, a, '0);
      n = 1;
    end else begin
      tr[0] = pk(0, 0, 1, 0, 1, a, '0);
      tr[1] = tr[0];
      n = 2;
    end
    tr[n] = pk(1, 0, 0, 0, 0, tgt, '0);
    exp_rd = ref_mem[tgt];
    if (we) ref_mem[tgt] = wd;
    else    exp_hold = exp_rd;

    @(negedge clk);
    check("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_indirect = ind; req_addr = a; req_wdata = wd;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_indirect = 1'($urandom);
      req_addr     = AW'($urandom);
      req_wdata    = DW'($urandom);
      check($sformatf("trace_c%0d", c + 1), obs(), tr[c]);
      if (we && c == lat - 2) check("wr_bus", {24'b0, mem_data}, {24'b0, wd});
    end
    check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp_hold});
    if (we) check("ram_wr", {24'b0, ram[tgt]}, {24'b0, wd});
  endtask

  // Four back-to-back requests with req_valid held high throughout.
  task automatic queued_test();
    bit            qwe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit            qind[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [AW-1:0] qa  [4] = '{12'h100, 12'h100, 12'h020, 12'h020};
    logic [DW-1:0] qd  [4] = '{8'hA5, 8'h00, 8'h77, 8'h00};
    logic [AW-1:0] tgt;
    logic [DW-1:0] exp_rd = '0;
    int            k = 0, c = 0, lat_cur = 0, n_rsp = 0;
    bit            cur_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = qwe[0]; req_indirect = qind[0]; req_addr = qa[0]; req_wdata = qd[0];
    for (int i = 0; i < 60; i++) begin
      if (c == 0) begin
        if (k == 4) break;
        tgt     = target(qind[k], qa[k]);
        lat_cur = latency(qwe[k], qind[k]);
        cur_we  = qwe[k];
        exp_rd  = ref_mem[tgt];
        if (qwe[k]) ref_mem[tgt] = qd[k];
        else        exp_hold = exp_rd;
        c = 1;
        k++;
      end else if (c == lat_cur) begin
        c = 0;
      end else begin
        c++;
      end
      @(negedge clk);
      if (c == 1) begin
        if (k < 4) begin
          req_we = qwe[k]; req_indirect = qind[k]; req_addr = qa[k]; req_wdata = qd[k];
        end else begin
          req_valid = 1'b0;
        end
      end
      check("q_ready", {31'b0, req_ready}, {31'b0, c == 0});
      check("q_rsp", {31'b0, rsp_valid}, {31'b0, c != 0 && c == lat_cur});
      if (rsp_valid === 1'b1) n_rsp++;
      if (c != 0 && c == lat_cur && !cur_we) check("q_rdata", {24'b0, rsp_rdata}, {24'b0, exp_rd});
    end
    req_valid = 1'b0;
    check("q_accepted", k, 4);
    check("q_rsp_count", n_rsp, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, summary required", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ptr;
    logic [DW-1:0] old;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 37 + 11);
    rst = 1'b1; ram_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    check("reset_bus", obs(), pk(0, 1, 0, 0, 0, '0, '0));
    check("reset_rdata", {24'b0, rsp_rdata}, 32'd0);
    rst = 1'b0;

    // Direct write then direct read.
    do_req(1'b1, 1'b0, 12'h005, 8'h3A);
    do_req(1'b0, 1'b0, 12'h005, 8'h00);
    check("direct_rd_3a", {24'b0, rsp_rdata}, 32'h3A);

    // Indirect write/read through pointer bytes 0x34, 0xF2 -> 0x234.
    preload(12'h010, 8'h34);
    preload(12'h011, 8'hF2);
    do_req(1'b1, 1'b1, 12'h010, 8'h5C);
    check("ind_ram_234", {24'b0, ram[12'h234]}, 32'h5C);
    do_req(1'b0, 1'b1, 12'h010, 8'h00);
    check("ind_rd_5c", {24'b0, rsp_rdata}, 32'h5C);

    // Pointer fetch wraps from 0xFFF to 0x000; target 0x001.
    preload(12'hFFF, 8'h01);
    preload(12'h000, 8'h00);
    do_req(1'b0, 1'b1, 12'hFFF, 8'h00);

    queued_test();

    for (int i = 0; i < 40; i++)
      do_req(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));

    // Reset during PTR_HI_W of an indirect write: the write must never land.
    ptr = target(1'b1, 12'h040);
    old = ref_mem[ptr];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_indirect = 1'b1; req_addr = 12'h040; req_wdata = ~old;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bus", obs(), pk(0, 1, 0, 0, 0, '0, '0));
    check("midrst_rdata", {24'b0, rsp_rdata}, 32'd0);
    exp_hold = '0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_quiet", {30'b0, rsp_valid, mem_cs}, 32'd0);
    end
    check("midrst_target", {24'b0, ram[ptr]}, {24'b0, old});

`ifdef RAM_BUS_MASTER_STATS_EN
    check("stat_rd_clr", {16'b0, stat_rd_count}, 32'd0);
    check("stat_wr_clr", {16'b0, stat_wr_count}, 32'd0);
    do_req(1'b1, 1'b1, 12'h010, 8'h11);
    do_req(1'b1, 1'b0, 12'h300, 8'h22);
    do_req(1'b0, 1'b0, 12'h300, 8'h00);
    do_req(1'b0, 1'b1, 12'h010, 8'h00);
    do_req(1'b0, 1'b0, 12'h005, 8'h00);
    @(negedge clk);
    check("stat_rd", {16'b0, stat_rd_count}, 32'd3);
    check("stat_wr", {16'b0, stat_wr_count}, 32'd2);
`endif

    do_req(1'b0, 1'b0, ptr, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
